i2c_recv_arbiter: RTL and testbench

Shares one I2C receive master between `NUM_REQ` requesters. Each requester posts a device address and a register address. The arbiter grants the requester in round-robin order, launches one read on the master, and returns the byte (or a timeout error) to the granted requester. It sits between the register-read clients and the I2C receive master; it is the only block that drives the master's enable and address inputs.

---
 rtl/i2c_recv_arbiter.sv | 179 +++++++++++++++++
 tb/tb_i2c_recv_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_recv_arbiter.sv
// i2c_recv_arbiter: round-robin arbiter sharing one I2C receive master between
// NUM_REQ register-read clients, with launch timeout and master-local reset.
`default_nettype none

module i2c_recv_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int GAP_CYC     = 16,
  parameter int MRST_CYC    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   i_req,
  input  logic [7*NUM_REQ-1:0] i_dev_addr,
  input  logic [8*NUM_REQ-1:0] i_reg_addr,
  output logic [NUM_REQ-1:0]   o_gnt,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [7:0]           o_rsp_data,
  output logic                 o_rsp_err,
  output logic                 o_busy,
  output logic                 o_m_recv_en,
  output logic [6:0]           o_m_dev_addr,
  output logic [7:0]           o_m_data_addr,
  output logic                 o_m_rst_n,
  input  logic                 i_m_done,
  input  logic [7:0]           i_m_read_data
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam int MW = $clog2(MRST_CYC + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GMAX = GW'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t             r_state;
  logic [LW-1:0]      r_last;
  logic [TW-1:0]      r_tcnt;
  logic [GW-1:0]      r_gcnt;
  logic [MW-1:0]      r_mcnt;
  logic [NUM_REQ-1:0] r_gnt;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [7:0]         r_rsp_data;
  logic               r_rsp_err;
  logic               r_busy;
  logic               r_recv_en;
  logic [6:0]         r_dev;
  logic [7:0]         r_reg;
  logic               r_mrst_n;

  logic               w_found;
  logic [LW-1:0]      w_win;
  logic [6:0]         w_dev;
  logic [7:0]         w_reg;

  function automatic logic [LW-1:0] f_rot(input logic [LW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[LW-1:0];
  endfunction

  // Scan from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_req[f_rot(r_last, i)]) begin
        w_found = 1'b1;
        w_win   = f_rot(r_last, i);
      end
    end
    w_dev = '0;
    w_reg = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_win == LW'(k)) begin
        w_dev = i_dev_addr[7*k +: 7];
        w_reg = i_reg_addr[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= LW'(NUM_REQ - 1);
      r_tcnt      <= '0;
      r_gcnt      <= '0;
      r_mcnt      <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= 8'h00;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_recv_en   <= 1'b0;
      r_dev       <= '0;
      r_reg       <= '0;
      r_mrst_n    <= 1'b0;
    end else begin
      r_recv_en   <= 1'b0;
      r_rsp_valid <= '0;
      // Master reset countdown; a zero count also releases it after rst_n.
      if (!r_mrst_n) begin
        if (r_mcnt == '0) r_mrst_n <= 1'b1;
        else              r_mcnt   <= r_mcnt - MW'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt        <= '0;
            r_gnt[w_win] <= 1'b1;
            r_dev        <= w_dev;
            r_reg        <= w_reg;
            r_last       <= w_win;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_recv_en <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (i_m_done) begin
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= i_m_read_data;
            r_rsp_err   <= 1'b0;
            r_gnt       <= '0;
            r_gcnt      <= '0;
            r_state     <= S_GAP;
          end else if (r_tcnt == TMAX) begin
            r_rsp_valid <= r_gnt;
            r_rsp_data  <= 8'h00;
            r_rsp_err   <= 1'b1;
            r_gnt       <= '0;
            r_gcnt      <= '0;
            r_mrst_n    <= 1'b0;
            r_mcnt      <= MW'(MRST_CYC - 1);
            r_state     <= S_GAP;
          end else begin
            r_tcnt <= r_tcnt + TW'(1);
          end
        end
        S_GAP: begin
          if (r_gcnt == GMAX) begin
            if (r_mrst_n) begin
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt         = r_gnt;
  assign o_rsp_valid   = r_rsp_valid;
  assign o_rsp_data    = r_rsp_data;
  assign o_rsp_err     = r_rsp_err;
  assign o_busy        = r_busy;
  assign o_m_recv_en   = r_recv_en;
  assign o_m_dev_addr  = r_dev;
  assign o_m_data_addr = r_reg;
  assign o_m_rst_n     = r_mrst_n;

endmodule

`default_nettype wire

// File: tb/tb_i2c_recv_arbiter.sv
// tb_i2c_recv_arbiter: directed and random traffic checked every cycle against a
// timestamp-based transaction model of the arbiter.
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_recv_arbiter;
  localparam int N = 4, TO = 400, GAP = 6, MR = 4;

  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] i_req = '0;
  logic [7*N-1:0] i_dev_addr = '0;
  logic [8*N-1:0] i_reg_addr = '0;
  logic i_m_done = 1'b0;
  logic [7:0] i_m_read_data = '0;
  logic [N-1:0] o_gnt, o_rsp_valid;
  logic [7:0] o_rsp_data, o_m_data_addr;
  logic [6:0] o_m_dev_addr;
  logic o_rsp_err, o_busy, o_m_recv_en, o_m_rst_n;

  i2c_recv_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(TO), .GAP_CYC(GAP), .MRST_CYC(MR)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_dev_addr(i_dev_addr), .i_reg_addr(i_reg_addr),
    .o_gnt(o_gnt), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .o_busy(o_busy), .o_m_recv_en(o_m_recv_en), .o_m_dev_addr(o_m_dev_addr),
    .o_m_data_addr(o_m_data_addr), .o_m_rst_n(o_m_rst_n), .i_m_done(i_m_done),
    .i_m_read_data(i_m_read_data));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Cycle count seen by the test processes (sampled on the falling edge).
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Stimulus control shared between the test and the agent processes.
  bit rand_mode = 0;
  int spur_div = 0, rsp_delay = -1, raise_id = 0, clr_id = 0;
  logic [7:0] rsp_byte = '0;
  logic [N-1:0] raise_mask = '0;
  logic [6:0] cmd_dev [N];
  logic [7:0] cmd_reg [N];

  task automatic post(input logic [N-1:0] m);
    raise_mask = m;
    raise_id++;
  endtask

  // Requesters: hold a request until its response strobe, then drop it.
  initial begin
    int raise_seen = 0, clr_seen = 0;
    forever begin
      @(negedge clk);
      if (clr_id != clr_seen) begin i_req = '0; clr_seen = clr_id; end
      if (raise_id != raise_seen) begin
        for (int k = 0; k < N; k++) if (raise_mask[k]) begin
          i_req[k] = 1'b1;
          i_dev_addr[7*k +: 7] = cmd_dev[k];
          i_reg_addr[8*k +: 8] = cmd_reg[k];
        end
        raise_seen = raise_id;
      end
      for (int k = 0; k < N; k++) begin
        if (i_req[k] && o_rsp_valid[k]) i_req[k] = 1'b0;
        else if (rand_mode) begin
          if (!i_req[k] && $urandom_range(0, 5) == 0) begin
            i_req[k] = 1'b1;
            i_dev_addr[7*k +: 7] = 7'($urandom);
            i_reg_addr[8*k +: 8] = 8'($urandom);
          end else if (i_req[k] && o_gnt[k] && $urandom_range(0, 59) == 0) i_req[k] = 1'b0;
        end
      end
    end
  end

  // Master: done is sampled at launch edge + delay; delay < 2 means never.
  initial begin
    int rcnt = -1, r;
    logic [7:0] rbyte = '0;
    forever begin
      @(negedge clk);
      i_m_done = 1'b0;
      if (!rst_n) rcnt = -1;
      else if (o_m_recv_en) begin
        if (rand_mode) begin
          r = int'($urandom_range(0, 19));
          rcnt = (r == 0) ? -1 : (r == 1) ? TO - 1 : (r == 2) ? TO + 4 : int'($urandom_range(1, 29));
          rbyte = 8'($urandom);
        end else begin
          rcnt = rsp_delay - 1;
          rbyte = rsp_byte;
        end
      end else if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin i_m_done = 1'b1; i_m_read_data = rbyte; rcnt = -1; end
      end else if (spur_div > 0 && o_gnt == '0 && $urandom_range(0, spur_div - 1) == 0) begin
        i_m_done = 1'b1;
        i_m_read_data = 8'($urandom);
      end
    end
  end

  // Transaction model: grant/launch/response/idle expressed as edge timestamps.
  int m_cyc = 0, m_owner = -1, m_last = N - 1, t_launch = 0, t_free = 0, t_rel = 0;
  logic [N-1:0] e_gnt = '0, e_rsp_valid = '0;
  logic [7:0] e_rsp_data = '0, e_reg = '0;
  logic [6:0] e_dev = '0;
  logic e_rsp_err = 0, e_busy = 0, e_recv_en = 0, e_mrst_n = 0;
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; t_free = 0; t_rel = 0;
      e_gnt = '0; e_rsp_valid = '0; e_rsp_data = '0; e_rsp_err = 0; e_busy = 0;
      e_recv_en = 0; e_dev = '0; e_reg = '0; e_mrst_n = 0;
    end else begin
      m_cyc++;
      e_recv_en = 0;
      e_rsp_valid = '0;
      if (m_owner < 0) begin
        if (m_cyc >= t_free && i_req != '0) begin
          for (int off = 1; off <= N; off++)
            if (m_owner < 0 && i_req[(m_last + off) % N]) m_owner = (m_last + off) % N;
          m_last = m_owner;
          e_gnt = N'(1) << m_owner;
          e_dev = i_dev_addr[7*m_owner +: 7];
          e_reg = i_reg_addr[8*m_owner +: 8];
          t_launch = m_cyc + 1;
        end
      end else if (m_cyc == t_launch) e_recv_en = 1;
      else if (i_m_done || m_cyc - t_launch == TO) begin
        e_rsp_valid = e_gnt;
        e_gnt = '0;
        m_owner = -1;
        if (i_m_done) begin
          e_rsp_data = i_m_read_data; e_rsp_err = 0;
          t_free = m_cyc + GAP + 1;
        end else begin
          e_rsp_data = 8'h00; e_rsp_err = 1;
          t_rel = m_cyc + MR;
          t_free = (m_cyc + GAP + 1 > t_rel + 2) ? m_cyc + GAP + 1 : t_rel + 2;
        end
      end
      e_busy = (m_owner >= 0) || (m_cyc < t_free - 1);
      e_mrst_n = (m_cyc >= t_rel);
    end
  end

  // Every-cycle comparison against the model, plus event counters.
  int n_launch = 0, n_rsp = 0;
  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      if (o_m_recv_en) n_launch++;
      if (o_rsp_valid != '0) n_rsp++;
      chk("gnt", 32'(o_gnt), 32'(e_gnt));
      chk("rsp_valid", 32'(o_rsp_valid), 32'(e_rsp_valid));
      chk("busy", 32'(o_busy), 32'(e_busy));
      chk("recv_en", 32'(o_m_recv_en), 32'(e_recv_en));
      chk("m_dev_addr", 32'(o_m_dev_addr), 32'(e_dev));
      chk("m_data_addr", 32'(o_m_data_addr), 32'(e_reg));
      chk("m_rst_n", 32'(o_m_rst_n), 32'(e_mrst_n));
      if (e_rsp_valid != '0) begin
        chk("rsp_data", 32'(o_rsp_data), 32'(e_rsp_data));
        chk("rsp_err", 32'(o_rsp_err), 32'(e_rsp_err));
      end
    end
  end

  task automatic wait_gnt(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_gnt != '0) begin at = cyc; break; end
    end
    if (at < 0) chk("grant_wait_expired", 0, 1);
  endtask

  task automatic wait_launch(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_m_recv_en) begin at = cyc; break; end
    end
    if (at < 0) chk("launch_wait_expired", 0, 1);
  endtask

  task automatic wait_rsp(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (o_rsp_valid != '0) begin at = cyc; break; end
    end
    if (at < 0) chk("response_wait_expired", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!o_busy && i_req == '0) begin ok = 1; break; end
    end
    if (!ok) chk("idle_wait_expired", 0, 1);
  endtask

  function automatic int oh2i(input logic [N-1:0] v);
    int r = -1;
    for (int k = 0; k < N; k++) if (v[k]) r = k;
    return r;
  endfunction

  initial begin
    int g, l, r, g2, n0, nz, prev_rsp;
    int order [3];
    for (int k = 0; k < N; k++) begin cmd_dev[k] = '0; cmd_reg[k] = '0; end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(o_gnt), 0);
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_rsp_data", 32'(o_rsp_data), 0);
    chk("reset_m_rst_n", 32'(o_m_rst_n), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("m_rst_n_after_release", 32'(o_m_rst_n), 1);

    // Round-robin from reset: requesters 0, 1, 3 held.
    rsp_delay = 20;
    for (int k = 0; k < N; k++) begin cmd_dev[k] = 7'($urandom); cmd_reg[k] = 8'($urandom); end
    n0 = n_launch;
    prev_rsp = -1000;
    post(4'b1011);
    for (int i = 0; i < 3; i++) begin
      wait_gnt(GAP + 10, g);
      order[i] = oh2i(o_gnt);
      if (i > 0) chk("rr_grant_spacing", 32'(g - prev_rsp >= GAP + 1), 1);
      wait_rsp(60, prev_rsp);
    end
    chk("rr_first", 32'(order[0]), 0);
    chk("rr_second", 32'(order[1]), 1);
    chk("rr_third", 32'(order[2]), 3);
    wait_idle(40);
    chk("rr_launches", 32'(n_launch - n0), 3);

    // Single read.
    cmd_dev[0] = 7'h50; cmd_reg[0] = 8'h10; rsp_delay = 300; rsp_byte = 8'hA5;
    n0 = n_launch;
    post(4'b0001);
    wait_gnt(10, g);
    chk("single_gnt", 32'(o_gnt), 32'h1);
    chk("single_dev", 32'(o_m_dev_addr), 32'h50);
    chk("single_reg", 32'(o_m_data_addr), 32'h10);
    wait_rsp(400, r);
    chk("single_rsp_valid", 32'(o_rsp_valid), 32'h1);
    chk("single_data", 32'(o_rsp_data), 32'hA5);
    chk("single_err", 32'(o_rsp_err), 0);
    chk("single_launches", 32'(n_launch - n0), 1);
    wait_idle(40);

    // Timeout, master reset pulse, and gap before next grant.
    rsp_delay = -1;
    post(4'b0100);
    wait_launch(10, l);
    wait_rsp(TO + 20, r);
    chk("to_latency", 32'(r - l), TO);
    chk("to_rsp_valid", 32'(o_rsp_valid), 32'h4);
    chk("to_err", 32'(o_rsp_err), 1);
    chk("to_data", 32'(o_rsp_data), 0);
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      if (o_m_rst_n) break;
      nz++;
      @(negedge clk);
    end
    chk("to_mrst_low_cycles", 32'(nz), MR);
    rsp_delay = 30; rsp_byte = 8'h77;
    post(4'b0001);
    wait_gnt(30, g2);
    chk("to_next_grant_gap", 32'(g2 - r), GAP + 1);
    wait_idle(80);

    // Done exactly in the cycle the timeout would fire.
    rsp_delay = TO; rsp_byte = 8'h3C;
    post(4'b1000);
    wait_launch(10, l);
    wait_rsp(TO + 20, r);
    chk("edge_latency", 32'(r - l), TO);
    chk("edge_rsp_valid", 32'(o_rsp_valid), 32'h8);
    chk("edge_err", 32'(o_rsp_err), 0);
    chk("edge_data", 32'(o_rsp_data), 32'h3C);
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      if (!o_m_rst_n) nz++;
      @(negedge clk);
    end
    chk("edge_mrst_low_cycles", 32'(nz), 0);
    wait_idle(40);

    // Spurious done pulses in IDLE and GAP.
    spur_div = 2;
    n0 = n_rsp;
    repeat (30) @(negedge clk);
    chk("spur_idle_rsp", 32'(n_rsp - n0), 0);
    chk("spur_idle_busy", 32'(o_busy), 0);
    rsp_delay = 15; rsp_byte = 8'h5A;
    post(4'b0001);
    wait_rsp(60, r);
    repeat (GAP + 6) @(negedge clk);
    chk("spur_gap_rsp", 32'(n_rsp - n0), 1);
    spur_div = 0;
    wait_idle(40);

    // Reset during WAIT clears state and the round-robin pointer.
    rsp_delay = -1;
    post(4'b0010);
    wait_gnt(10, g);
    chk("pre_reset_gnt", 32'(o_gnt), 32'h2);
    repeat (5) @(negedge clk);
    post(4'b0110);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_gnt", 32'(o_gnt), 0);
    chk("async_busy", 32'(o_busy), 0);
    chk("async_m_rst_n", 32'(o_m_rst_n), 0);
    chk("async_dev", 32'(o_m_dev_addr), 0);
    rsp_delay = 10; rsp_byte = 8'h11;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(10, g);
    chk("post_reset_gnt", 32'(o_gnt), 32'h2);
    wait_idle(100);

    // Randomised traffic.
    spur_div = 8;
    rand_mode = 1;
    repeat (3000) @(negedge clk);
    rand_mode = 0;
    spur_div = 0;
    clr_id++;
    wait_idle(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
